// File: rtl/code_stream_decoder.sv
// Serial-to-nibble receiver: frames MSB-first bits into 4-bit words, decodes per
// latched mode (Gray/XS3/raw) and hands words out through a valid/ready register.
module code_stream_decoder #(
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           mode,
    input  logic                 sync,
    input  logic                 s_valid,
    input  logic                 s_bit,
    output logic                 s_ready,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [3:0]           m_data,
    output logic                 m_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        ModeGray = 2'b00,
        ModeXs3  = 2'b01,
        ModeRaw  = 2'b10,
        ModeRsvd = 2'b11
    } mode_e;

    logic [3:0]           shift_q;
    logic [1:0]           bit_cnt_q;
    mode_e                mode_q;
    logic                 m_valid_q;
    logic [3:0]           m_data_q;
    logic                 m_err_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;

    logic       accept;
    logic       complete;
    logic       drain;
    logic [3:0] word;
    logic [3:0] dec_data;
    logic       dec_err;

    // The 4th bit is held off only while an unconsumed word sits in the output register.
    assign s_ready  = (bit_cnt_q != 2'd3) || !m_valid_q || m_ready;
    assign accept   = s_valid && s_ready && !sync;
    assign complete = accept && (bit_cnt_q == 2'd3);
    assign drain    = m_valid_q && m_ready;
    assign word     = {shift_q[2:0], s_bit};

    always_comb begin
        dec_data = 4'd0;
        dec_err  = 1'b0;
        unique case (mode_q)
            ModeGray: begin
                dec_data[3] = word[3];
                for (int i = 2; i >= 0; i--) begin
                    dec_data[i] = dec_data[i+1] ^ word[i];
                end
            end
            ModeXs3: begin
                if (word >= 4'd3 && word <= 4'd12) begin
                    dec_data = word - 4'd3;
                end else begin
                    dec_err = 1'b1;
                end
            end
            ModeRaw:  dec_data = word;
            ModeRsvd: dec_err  = 1'b1;
            default:  dec_err  = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q   <= 4'd0;
            bit_cnt_q <= 2'd0;
            mode_q    <= ModeGray;
        end else begin
            if (sync) begin
                bit_cnt_q <= 2'd0;
            end else if (accept) begin
                shift_q   <= word;
                bit_cnt_q <= bit_cnt_q + 2'd1;
                if (bit_cnt_q == 2'd0) begin
                    mode_q <= mode_e'(mode);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            m_data_q  <= 4'd0;
            m_err_q   <= 1'b0;
        end else if (complete) begin
            m_valid_q <= 1'b1;
            m_data_q  <= dec_data;
            m_err_q   <= dec_err;
        end else if (drain) begin
            m_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (drain && m_err_q && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_err   = m_err_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: doc/code_stream_decoder.md
# code_stream_decoder

Receive-side partner of the 4-bit code converter. Accepts encoded nibbles as a bit-serial stream (MSB first), frames them into 4-bit words, and decodes each word to plain binary according to a per-word mode (Gray, Excess-3, raw). Decoded words leave through a valid/ready output register, which lets the block sit between a serial link front end and any nibble consumer on the FPGA. An invalid-code flag accompanies each word, and a saturating error counter records how many flagged words the block has delivered.

## Interface
Parameters:
- ERR_CNT_W, 8, width of the saturating error counter

Ports:
- clk  in  1  system clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-high reset
- mode  in  2  decode mode, sampled with the first bit of each word: 00 Gray->bin, 01 XS3->bin, 10 raw, 11 reserved
- sync  in  1  framing restart; discards any partially assembled word
- s_valid  in  1  serial bit present on s_bit
- s_bit  in  1  serial data bit, MSB first
- s_ready  out  1  block accepts s_bit this cycle
- m_valid  out  1  decoded word present on m_data/m_err
- m_ready  in  1  consumer accepts the word this cycle
- m_data  out  4  decoded binary value
- m_err  out  1  word was an invalid code for its mode
- err_cnt  out  ERR_CNT_W  number of words delivered with m_err=1, saturating

## Operation
- **Bit acceptance.** A bit is accepted when s_valid && s_ready. The accepted bit shifts into a 4-bit register from the LSB end, so the first bit becomes bit 3. A 2-bit counter, bit_cnt, tracks how many bits have been accepted in the current word (0..3).
- **Mode latch.** When a bit is accepted with bit_cnt==0, mode is captured into mode_q. Changes to mode in the middle of a word have no effect on that word.
- **Word completion.** A word completes when a bit is accepted with bit_cnt==3. The block then decodes the word formed by the 3 shifted bits plus the incoming bit, loads the result into the output register, and wraps bit_cnt to 0.
- **s_ready.** s_ready = (bit_cnt != 3) || !m_valid || m_ready. The 4th bit is held off only when the output register is full and not draining, so the output register never overwrites an unconsumed word.
- **Decode rules** (w is the assembled word):
  - Gray (00): b3=w3; bi=b(i+1)^wi for i=2..0; m_err=0.
  - XS3 (01): valid range is 3..12. In range: m_data = w-3, computed modulo 4 bits, with m_err=0. Out of range: m_data=0, m_err=1.
  - Raw (10): m_data=w; m_err=0.
  - Reserved (11): m_data=0; m_err=1.
- **Output register.**
  - m_valid sets on word completion.
  - m_valid clears on m_valid && m_ready, unless a new word completes in the same cycle; in that case it stays at 1 with the new data.
  - m_data and m_err hold steady while m_valid && !m_ready.
- **Error counter.** err_cnt increments on m_valid && m_ready && m_err. It saturates at all-ones and does not wrap.
- **sync.**
  - When sync=1, bit_cnt goes to 0 and any bit presented that cycle is discarded, even if s_valid=1. s_ready still follows its formula.
  - sync has no effect on the output register or on err_cnt.
  - A word whose 4th bit arrives in the same cycle as sync is discarded.

## Timing
- Reset values: s_ready=1, m_valid=0, m_data=0, m_err=0, err_cnt=0, bit_cnt=0, mode_q=00, shift register=0.
- Reset asserted in the middle of a word discards the partial word and any pending output word immediately, without waiting for a clock edge.
- Latency: m_valid rises on the clock edge that accepts the 4th bit, so the word is visible the cycle after that bit is presented.
- Throughput: one bit per clock and one word per 4 clocks under continuous s_valid with m_ready=1.
- Back-to-back is supported: the 4th bit of word N+1 may complete in the same cycle that word N drains.
- Backpressure reaches the serial side only at the word boundary (bit_cnt==3). Bits 1-3 of the next word are accepted even while the output register is stalled.
- All outputs are registered except s_ready, which is combinational from bit_cnt, m_valid and m_ready.

## Test plan
- **Reset.** Assert rst asynchronously in the middle of a word after 2 bits. Required: m_valid=0, err_cnt=0 and s_ready=1 immediately. After release, send raw bits 1,0,1,1 -> m_data=1011, m_err=0.
- **Gray and XS3 decode.**
  - mode=00, send 0,1,1,0 -> m_data=0100, m_err=0.
  - mode=01, send 1,0,0,0 -> m_data=0101, m_err=0.
  - mode=01, send 1,1,0,1 -> m_data=0000, m_err=1, and err_cnt=1 after the handshake.
  - Sweep all 16 codes in each mode against a reference model.
- **Backpressure.** m_ready=0, stream two words with continuous s_valid. Required: the first word is held stable; s_ready=0 once bit_cnt==3 of the second word. Raise m_ready for 1 cycle -> the first word drains and the second loads in the same cycle with m_valid staying 1.
- **sync.** Send 2 bits, pulse sync for 1 cycle with s_valid=1, then send 0,0,1,1 in raw mode -> exactly one word, m_data=0011. Both the pre-sync bits and the bit presented during sync are lost.
- **Mode latch.** Start an XS3 word and switch mode to 00 after the 1st bit; send 0,1,1,1 -> m_data=0100 (XS3 rule applied).
- **Saturation.** With ERR_CNT_W=2, deliver 5 reserved-mode words -> err_cnt sequence 1,2,3,3,3.
